// File: rtl/trap_seq_ctrl.sv
// Trap-entry / mret sequencer for the machine-mode CSR path.
// Optional build macro TRAP_VECTORED_EN: vectored interrupt targets when mtvec mode is 01.
module trap_seq_ctrl #(
   parameter int FLUSH_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        exc_valid,
   input  logic [4:0]  exc_cause,
   input  logic [31:0] exc_tval,
   input  logic        irq_pending,
   input  logic [4:0]  irq_cause,
   input  logic        mstatus_mie,
   input  logic        mret_req,
   input  logic [31:0] mepc_adr,
   input  logic [31:0] mepc_q,
   input  logic [31:0] mtvec_q,
   input  logic        pc_redirect_ready,
   output logic        flush_pipe,
   output logic        stall_if,
   output logic        clear_counter,
   output logic        mepc_we,
   output logic [31:0] mepc_wdata,
   output logic        mcause_we,
   output logic [31:0] mcause_wdata,
   output logic        mtval_we,
   output logic [31:0] mtval_wdata,
   output logic        mstatus_trap,
   output logic        mstatus_mret,
   output logic        pc_redirect_valid,
   output logic [31:0] pc_redirect_target,
   output logic        busy
);

   typedef enum logic [2:0] {IDLE, FLUSH, CAPTURE, REDIRECT, MRET} state_t;

   localparam logic [3:0] CNT_LOAD = 4'(FLUSH_CYCLES - 1);

   state_t      state, state_nxt;
   logic [3:0]  cnt;
   logic [4:0]  cause;
   logic [31:0] tval;
   logic        irq_flag;
   logic [31:0] target;
   logic [31:0] trap_vec;

   logic unused_bits;
   assign unused_bits = &{1'b0, mepc_adr[1:0], mepc_q[1:0], mtvec_q[1:0]};

`ifdef TRAP_VECTORED_EN
   always_comb begin
      trap_vec = {mtvec_q[31:2], 2'b00};
      if (mtvec_q[1:0] == 2'b01 && irq_flag)
         trap_vec = trap_vec + {25'b0, cause, 2'b00};
   end
`else
   assign trap_vec = {mtvec_q[31:2], 2'b00};
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= 4'd0;
         cause    <= 5'd0;
         tval     <= 32'd0;
         irq_flag <= 1'b0;
         target   <= 32'd0;
      end else begin
         state <= state_nxt;
         case (state)
            IDLE: begin
               cnt <= CNT_LOAD;
               if (exc_valid) begin
                  cause    <= exc_cause;
                  tval     <= exc_tval;
                  irq_flag <= 1'b0;
               end else if (!mret_req && irq_pending && mstatus_mie) begin
                  cause    <= irq_cause;
                  tval     <= 32'd0;
                  irq_flag <= 1'b1;
               end
            end
            FLUSH:   if (cnt != 4'd0) cnt <= cnt - 4'd1;
            CAPTURE: target <= trap_vec;
            MRET:    target <= {mepc_q[31:2], 2'b00};
            default: ;
         endcase
      end
   end

   always_comb begin
      state_nxt          = state;
      flush_pipe         = 1'b0;
      stall_if           = 1'b0;
      clear_counter      = 1'b0;
      mepc_we            = 1'b0;
      mepc_wdata         = 32'd0;
      mcause_we          = 1'b0;
      mcause_wdata       = 32'd0;
      mtval_we           = 1'b0;
      mtval_wdata        = 32'd0;
      mstatus_trap       = 1'b0;
      mstatus_mret       = 1'b0;
      pc_redirect_valid  = 1'b0;
      pc_redirect_target = 32'd0;
      busy               = (state != IDLE);
      case (state)
         IDLE: begin
            if (exc_valid)                        state_nxt = FLUSH;
            else if (mret_req)                    state_nxt = MRET;
            else if (irq_pending && mstatus_mie)  state_nxt = FLUSH;
         end
         FLUSH: begin
            flush_pipe    = 1'b1;
            stall_if      = 1'b1;
            // counter still holds its load value only on the first flush cycle
            clear_counter = (cnt == CNT_LOAD);
            if (cnt == 4'd0) state_nxt = CAPTURE;
         end
         CAPTURE: begin
            stall_if     = 1'b1;
            mepc_we      = 1'b1;
            mepc_wdata   = {mepc_adr[31:2], 2'b00};
            mcause_we    = 1'b1;
            mcause_wdata = {irq_flag, 26'b0, cause};
            mtval_we     = 1'b1;
            mtval_wdata  = tval;
            mstatus_trap = 1'b1;
            state_nxt    = REDIRECT;
         end
         MRET: begin
            flush_pipe   = 1'b1;
            stall_if     = 1'b1;
            mstatus_mret = 1'b1;
            state_nxt    = REDIRECT;
         end
         REDIRECT: begin
            stall_if           = 1'b1;
            pc_redirect_valid  = 1'b1;
            pc_redirect_target = target;
            if (pc_redirect_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_trap_seq_ctrl.sv
// Directed bench for trap_seq_ctrl: reset, exception, interrupt, mret, collisions.
module tb_trap_seq_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        exc_valid;
   logic [4:0]  exc_cause;
   logic [31:0] exc_tval;
   logic        irq_pending;
   logic [4:0]  irq_cause;
   logic        mstatus_mie;
   logic        mret_req;
   logic [31:0] mepc_adr;
   logic [31:0] mepc_q;
   logic [31:0] mtvec_q;
   logic        pc_redirect_ready;
   logic        flush_pipe, stall_if, clear_counter;
   logic        mepc_we, mcause_we, mtval_we;
   logic [31:0] mepc_wdata, mcause_wdata, mtval_wdata;
   logic        mstatus_trap, mstatus_mret;
   logic        pc_redirect_valid;
   logic [31:0] pc_redirect_target;
   logic        busy;

   int cmp = 0;
   int mis = 0;

   logic [9:0] ctl;
   logic [31:0] dat;
   assign ctl = {flush_pipe, stall_if, clear_counter, mepc_we, mcause_we, mtval_we,
                 mstatus_trap, mstatus_mret, pc_redirect_valid, busy};
   assign dat = mepc_wdata | mcause_wdata | mtval_wdata | pc_redirect_target;

   always #5 clk = ~clk;

   trap_seq_ctrl #(.FLUSH_CYCLES(2)) dut (
      .clk(clk), .reset(reset),
      .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_tval(exc_tval),
      .irq_pending(irq_pending), .irq_cause(irq_cause), .mstatus_mie(mstatus_mie),
      .mret_req(mret_req), .mepc_adr(mepc_adr), .mepc_q(mepc_q), .mtvec_q(mtvec_q),
      .pc_redirect_ready(pc_redirect_ready),
      .flush_pipe(flush_pipe), .stall_if(stall_if), .clear_counter(clear_counter),
      .mepc_we(mepc_we), .mepc_wdata(mepc_wdata),
      .mcause_we(mcause_we), .mcause_wdata(mcause_wdata),
      .mtval_we(mtval_we), .mtval_wdata(mtval_wdata),
      .mstatus_trap(mstatus_trap), .mstatus_mret(mstatus_mret),
      .pc_redirect_valid(pc_redirect_valid), .pc_redirect_target(pc_redirect_target),
      .busy(busy)
   );

   // ctl bit order: flush stall clr mepc_we mcause_we mtval_we trap mret valid busy
   task automatic test_reset_and_exc();
      reset = 1'b1; exc_valid = 1'b1; exc_cause = 5'd2; exc_tval = 32'hDEADBEEF;
      mepc_adr = 32'h0000_0106; mtvec_q = 32'h8000_0000; pc_redirect_ready = 1'b1;
      repeat (2) @(negedge clk);
      cmp++; if (ctl !== 10'b0 || dat !== 32'd0) begin mis++;
         $display("FAIL reset_outputs ctl=%b dat=%h want 0", ctl, dat); end
      reset = 1'b0;
      @(negedge clk);
      cmp++; if (ctl !== 10'b1110000001) begin mis++;
         $display("FAIL exc_flush1 ctl=%b want 1110000001", ctl); end
      exc_valid = 1'b0;
      @(negedge clk);
      cmp++; if (ctl !== 10'b1100000001) begin mis++;
         $display("FAIL exc_flush2 ctl=%b want 1100000001", ctl); end
      @(negedge clk);
      cmp++; if (ctl !== 10'b0101111001) begin mis++;
         $display("FAIL exc_capture_ctl ctl=%b want 0101111001", ctl); end
      cmp++; if (mepc_wdata !== 32'h0000_0104 || mcause_wdata !== 32'h0000_0002
                 || mtval_wdata !== 32'hDEADBEEF) begin mis++;
         $display("FAIL exc_capture_data mepc=%h mcause=%h mtval=%h want 00000104 00000002 deadbeef",
                  mepc_wdata, mcause_wdata, mtval_wdata); end
      @(negedge clk);
      cmp++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h8000_0000) begin mis++;
         $display("FAIL exc_redirect valid=%b tgt=%h want 1 80000000", pc_redirect_valid, pc_redirect_target); end
      @(negedge clk);
      cmp++; if (busy !== 1'b0 || pc_redirect_valid !== 1'b0) begin mis++;
         $display("FAIL exc_idle busy=%b valid=%b want 0 0", busy, pc_redirect_valid); end
   endtask

   task automatic test_irq();
      logic [31:0] exp_tgt;
`ifdef TRAP_VECTORED_EN
      exp_tgt = 32'h8000_001C;
`else
      exp_tgt = 32'h8000_0000;
`endif
      irq_pending = 1'b1; irq_cause = 5'd7; mstatus_mie = 1'b0; mtvec_q = 32'h8000_0001;
      mepc_adr = 32'h0000_0400;
      repeat (2) @(negedge clk);
      cmp++; if (busy !== 1'b0) begin mis++;
         $display("FAIL irq_masked busy=%b want 0", busy); end
      mstatus_mie = 1'b1;
      @(negedge clk);
      cmp++; if (busy !== 1'b1 || flush_pipe !== 1'b1) begin mis++;
         $display("FAIL irq_flush busy=%b flush=%b want 1 1", busy, flush_pipe); end
      irq_pending = 1'b0; mstatus_mie = 1'b0;
      repeat (2) @(negedge clk);
      cmp++; if (mcause_we !== 1'b1 || mcause_wdata !== 32'h8000_0007 || mtval_wdata !== 32'd0
                 || mepc_wdata !== 32'h0000_0400) begin mis++;
         $display("FAIL irq_capture we=%b mcause=%h mtval=%h mepc=%h want 1 80000007 0 00000400",
                  mcause_we, mcause_wdata, mtval_wdata, mepc_wdata); end
      @(negedge clk);
      cmp++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== exp_tgt) begin mis++;
         $display("FAIL irq_target valid=%b tgt=%h want 1 %h", pc_redirect_valid, pc_redirect_target, exp_tgt); end
      @(negedge clk);
   endtask

   task automatic test_mret();
      mepc_q = 32'h0000_2000; pc_redirect_ready = 1'b0; mret_req = 1'b1;
      @(negedge clk);
      cmp++; if (ctl !== 10'b1100000101) begin mis++;
         $display("FAIL mret_pulse ctl=%b want 1100000101", ctl); end
      mret_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cmp++; if (pc_redirect_valid !== 1'b1 || pc_redirect_target !== 32'h0000_2000) begin mis++;
            $display("FAIL mret_hold%0d valid=%b tgt=%h want 1 00002000", i, pc_redirect_valid, pc_redirect_target); end
      end
      pc_redirect_ready = 1'b1;
      @(negedge clk);
      cmp++; if (busy !== 1'b0 || pc_redirect_valid !== 1'b0) begin mis++;
         $display("FAIL mret_idle busy=%b valid=%b want 0 0", busy, pc_redirect_valid); end
   endtask

   task automatic test_exc_mret_collide();
      int mret_seen = 0;
      int we_seen = 0;
      exc_valid = 1'b1; mret_req = 1'b1; exc_cause = 5'd4; exc_tval = 32'h0000_1234;
      mepc_adr = 32'h0000_0203; mtvec_q = 32'h0000_1000; pc_redirect_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exc_valid = 1'b0; mret_req = 1'b0;
         if (mstatus_mret) mret_seen++;
         if (mepc_we) begin
            we_seen++;
            cmp++; if (mepc_wdata !== 32'h0000_0200 || mcause_wdata !== 32'h0000_0004) begin mis++;
               $display("FAIL collide_capture mepc=%h mcause=%h want 00000200 00000004", mepc_wdata, mcause_wdata); end
         end
      end
      cmp++; if (mret_seen !== 0 || we_seen !== 1) begin mis++;
         $display("FAIL collide_seq mret_pulses=%0d mepc_we=%0d want 0 1", mret_seen, we_seen); end
      cmp++; if (busy !== 1'b0) begin mis++;
         $display("FAIL collide_idle busy=%b want 0", busy); end
   endtask

   task automatic test_reset_mid();
      int we_seen = 0;
      exc_valid = 1'b1;
      @(negedge clk);
      cmp++; if (flush_pipe !== 1'b1) begin mis++;
         $display("FAIL mid_flush flush=%b want 1", flush_pipe); end
      exc_valid = 1'b0; reset = 1'b1;
      @(negedge clk);
      cmp++; if (ctl !== 10'b0 || dat !== 32'd0) begin mis++;
         $display("FAIL mid_reset ctl=%b dat=%h want 0", ctl, dat); end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (mepc_we) we_seen++;
      end
      cmp++; if (we_seen !== 0 || busy !== 1'b0) begin mis++;
         $display("FAIL mid_no_capture mepc_we=%0d busy=%b want 0 0", we_seen, busy); end
   endtask

   initial begin
      reset = 1'b1; exc_valid = 1'b0; exc_cause = '0; exc_tval = '0;
      irq_pending = 1'b0; irq_cause = '0; mstatus_mie = 1'b0; mret_req = 1'b0;
      mepc_adr = '0; mepc_q = '0; mtvec_q = '0; pc_redirect_ready = 1'b0;
      test_reset_and_exc();
      test_irq();
      test_mret();
      test_exc_mret_collide();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
   end

endmodule

// File: doc/trap_seq_ctrl.md
# trap_seq_ctrl

Trap-entry and `mret` sequencer for the machine-mode CSR path. It accepts an exception from the mem stage, a pending interrupt, or an `mret` request. It then flushes the pipeline, lets the mepc address selector settle, and writes `mepc`/`mcause`/`mtval` in a single cycle. Finally it redirects fetch to the handler or the return address through a valid/ready handshake.

## Interface
- `FLUSH_CYCLES`, default 2: cycles `flush_pipe` is held before capture; legal range 1–15.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `exc_valid` in 1: mem-stage exception; held by the source until `busy` is seen.
- `exc_cause` in 5: exception code.
- `exc_tval` in 32: faulting address or instruction.
- `irq_pending` in 1: external/timer interrupt pending, level.
- `irq_cause` in 5: interrupt code.
- `mstatus_mie` in 1: global interrupt enable.
- `mret_req` in 1: `mret` retiring in mem stage.
- `mepc_adr` in 32: address from the mepc address selector.
- `mepc_q` in 32: current `mepc` CSR value.
- `mtvec_q` in 32: current `mtvec`; [1:0] is mode.
- `pc_redirect_ready` in 1: fetch accepts the redirect.
- `flush_pipe` out 1: clear all pipeline registers.
- `stall_if` out 1: hold fetch.
- `clear_counter` out 1: one-cycle pulse to the selector's counter.
- `mepc_we` out 1, `mepc_wdata` out 32.
- `mcause_we` out 1, `mcause_wdata` out 32.
- `mtval_we` out 1, `mtval_wdata` out 32.
- `mstatus_trap` out 1: pulse; MPIE←MIE, MIE←0.
- `mstatus_mret` out 1: pulse; MIE←MPIE, MPIE←1.
- `pc_redirect_valid` out 1, `pc_redirect_target` out 32.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, FLUSH, CAPTURE, REDIRECT, MRET.
- IDLE: all outputs 0.
  - Priority 1: `exc_valid` → FLUSH. Latch `exc_cause`, `exc_tval`, irq flag = 0.
  - Priority 2: `mret_req` → MRET.
  - Priority 3: `irq_pending & mstatus_mie` → FLUSH. Latch `irq_cause`, tval = 0, irq flag = 1.
- FLUSH:
  - `flush_pipe` = `stall_if` = 1.
  - `clear_counter` = 1 on the first FLUSH cycle only.
  - 4-bit down-counter loaded with `FLUSH_CYCLES-1` on entry; on 0 → CAPTURE.
- CAPTURE, exactly 1 cycle:
  - `stall_if` = 1.
  - `mepc_we` = 1 with `mepc_wdata = {mepc_adr[31:2], 2'b00}`.
  - `mcause_we` = 1 with `{irq_flag, 26'b0, cause}`.
  - `mtval_we` = 1 with latched tval.
  - `mstatus_trap` = 1.
  - Target register ← trap vector. → REDIRECT.
- MRET, exactly 1 cycle:
  - `flush_pipe` = `stall_if` = `mstatus_mret` = 1.
  - Target ← `{mepc_q[31:2], 2'b00}`. → REDIRECT.
- REDIRECT:
  - `stall_if` = 1, `pc_redirect_valid` = 1.
  - Target is stable while valid is asserted.
  - On `pc_redirect_valid & pc_redirect_ready` → IDLE.
- Requests arriving outside IDLE are ignored; sources hold them.
- Trap vector: `{mtvec_q[31:2], 2'b00}`, plus the vectored offset described under Configuration.
- All arithmetic is 32-bit; wrap-around is modulo 2^32.

## Timing
- Reset value: every output 0, state IDLE, counter 0, latched cause/tval/target 0.
- Reset asserted mid-sequence returns to IDLE on the next edge. CSR writes are single-cycle, so no partial CSR update is possible.
- Trap latency, request to first `pc_redirect_valid`: 1 (IDLE→FLUSH) + `FLUSH_CYCLES` + 1 (CAPTURE) cycles. With the default this is 4 cycles.
- `mret` latency, request to `pc_redirect_valid`: 2 cycles.
- If `pc_redirect_ready` is already high when REDIRECT is entered, REDIRECT lasts 1 cycle. Otherwise valid stays high until ready is seen.
- Simultaneous `exc_valid` and `mret_req`: the exception wins and `mret` is dropped. Simultaneous exception and interrupt: the exception wins and the interrupt is re-evaluated when the block returns to IDLE.
- `mepc_adr` is sampled only in CAPTURE.

## Configuration
- `TRAP_VECTORED_EN` defined: if `mtvec_q[1:0]==2'b01` and the trap is an interrupt, target = base + (cause << 2). Exceptions always use the base.
- Not defined: `mtvec_q[1:0]` is ignored and every trap targets the base. No vector adder is synthesized.

## Test plan
- Reset with `exc_valid=1` held → all outputs 0 during reset. After release: FLUSH 2 cycles, then CAPTURE.
- `exc_valid`, cause=2, tval=0xDEADBEEF, `mepc_adr`=0x0000_0106, `mtvec_q`=0x8000_0000:
  - CAPTURE writes mepc=0x0000_0104, mcause=0x0000_0002, mtval=0xDEADBEEF.
  - Redirect target is 0x8000_0000 at cycle 4.
- `irq_pending=1`, `mstatus_mie=0` → stays IDLE. Raise MIE with cause=7, `mtvec_q`=0x8000_0001, vectored build:
  - mcause=0x8000_0007, target=0x8000_001C.
  - Non-vectored build: target=0x8000_0000.
- `mret_req` with `mepc_q`=0x0000_2000 → `mstatus_mret` pulse, then valid/target 0x0000_2000 2 cycles after the request. With `pc_redirect_ready` low for 3 cycles, valid and target are held steady until ready.
- `exc_valid` and `mret_req` in the same cycle → trap sequence only, no `mstatus_mret` pulse.
- Reset asserted during FLUSH → no `mepc_we` pulse, outputs 0 next cycle.
